// File: rtl/uart_boot_loader.sv
// uart_boot_loader
//
// Receives a program image over an 8N1 UART line and writes it word by word
// into instruction memory, holding the core in reset until the image is in.
// Image format: 4-byte little-endian word count N, then N 32-bit
// little-endian words. Word k is written to byte address 4*k.
//
// Ports:
//   clk_i                 system clock, rising edge
//   reset_i               synchronous active-high reset; aborts any load
//   uart_rx_i             asynchronous serial input, idle high, LSB first
//   instr_write_enable_o  one-cycle write strobe to instruction memory
//   instr_address_o       byte address of the word being written
//   instr_data_o          instruction word being written
//   core_reset_o          high while the core must stay in reset
//   busy_o                high from the first start bit until DONE or ERROR
//   error_o               sticky fault flag (framing error or oversize image)
//
// Write port handshake: instr_write_enable_o is a valid-only strobe with no
// ready; the memory must accept the write in the cycle the strobe is high.
// Address and data stay stable until the next strobe.
//
// FSM state is observable for checkers through the internal signals
// rx_state and ld_state.

module uart_boot_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int MEM_WORDS    = 256
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        uart_rx_i,
  output logic        instr_write_enable_o,
  output logic [31:0] instr_address_o,
  output logic [31:0] instr_data_o,
  output logic        core_reset_o,
  output logic        busy_o,
  output logic        error_o
);

  localparam int              CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]   BIT_M1    = CW'(CLKS_PER_BIT - 1);
  localparam logic [31:0]     MAX_WORDS = 32'(MEM_WORDS);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {L_LEN, L_LOAD, L_DONE, L_ERROR}      ld_state_t;

  // ---------------------------------------------------------------------
  // Input synchronizer (resets to the idle-high line level)
  // ---------------------------------------------------------------------
  logic rx_meta;
  logic rx_sync;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rx_i;
      rx_sync <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------
  rx_state_t     rx_state;
  rx_state_t     rx_next;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    rx_shift;
  logic          byte_valid;
  logic          bit_tick;
  logic          stop_ok;
  logic          stop_bad;

  always_comb begin
    rx_next  = rx_state;
    bit_tick = 1'b0;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    case (rx_state)
      RX_IDLE:  if (!rx_sync) rx_next = RX_START;
      // Mid-bit check of the start bit: a high line here means a glitch.
      RX_START: if (rx_cnt == HALF_M1) rx_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA: begin
        if (rx_cnt == BIT_M1) begin
          bit_tick = 1'b1;
          if (bit_idx == 3'd7) rx_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_M1) begin
          rx_next  = RX_IDLE;
          stop_ok  = rx_sync;
          stop_bad = !rx_sync;
        end
      end
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) rx_state <= RX_IDLE;
    else         rx_state <= rx_next;
  end

  // The bit counter restarts on every state change and on every data-bit
  // sample, so each later sample lands one full bit period after the last.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_cnt     <= '0;
      bit_idx    <= 3'd0;
      rx_shift   <= 8'h00;
      byte_valid <= 1'b0;
    end else begin
      byte_valid <= stop_ok;
      if ((rx_next != rx_state) || bit_tick) rx_cnt <= '0;
      else                                   rx_cnt <= rx_cnt + CW'(1);
      if (rx_state == RX_START) begin
        bit_idx <= 3'd0;
      end else if (bit_tick) begin
        bit_idx  <= bit_idx + 3'd1;
        rx_shift <= {rx_sync, rx_shift[7:1]};
      end
    end
  end

  // ---------------------------------------------------------------------
  // Loader FSM
  // ---------------------------------------------------------------------
  ld_state_t   ld_state;
  ld_state_t   ld_next;
  logic [1:0]  byte_cnt;
  logic [31:0] word_sr;
  logic [31:0] word_full;
  logic [31:0] n_words;
  logic [31:0] k;
  logic        word_done;
  logic        accepting;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic        busy_q;

  // Bytes shift in from the top, so after four bytes the first one sits in
  // bits [7:0] (little-endian assembly).
  assign word_full = {rx_shift, word_sr[31:8]};
  assign accepting = (ld_state == L_LEN) || (ld_state == L_LOAD);
  assign word_done = byte_valid && (byte_cnt == 2'd3);

  always_comb begin
    ld_next = ld_state;
    case (ld_state)
      L_LEN: begin
        if (stop_bad) begin
          ld_next = L_ERROR;
        end else if (word_done) begin
          if (word_full == 32'd0)           ld_next = L_DONE;
          else if (word_full > MAX_WORDS)   ld_next = L_ERROR;
          else                              ld_next = L_LOAD;
        end
      end
      // Leave one cycle after the final strobe so the core is released only
      // once the last word is in memory.
      L_LOAD: begin
        if (we_q && (k == n_words)) ld_next = L_DONE;
        else if (stop_bad)          ld_next = L_ERROR;
      end
      default: ld_next = ld_state;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) ld_state <= L_LEN;
    else         ld_state <= ld_next;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      byte_cnt <= 2'd0;
      word_sr  <= 32'd0;
      n_words  <= 32'd0;
      k        <= 32'd0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      data_q   <= 32'd0;
      busy_q   <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (byte_valid && accepting) begin
        word_sr  <= word_full;
        byte_cnt <= byte_cnt + 2'd1;
      end
      if (word_done && (ld_state == L_LEN)) begin
        n_words <= word_full;
        k       <= 32'd0;
      end
      if (word_done && (ld_state == L_LOAD)) begin
        we_q   <= 1'b1;
        addr_q <= {k[29:0], 2'b00};
        data_q <= word_full;
        k      <= k + 32'd1;
      end
      if ((ld_next == L_DONE) || (ld_next == L_ERROR)) busy_q <= 1'b0;
      else if ((rx_state == RX_IDLE) && !rx_sync)      busy_q <= 1'b1;
    end
  end

  assign instr_write_enable_o = we_q;
  assign instr_address_o      = addr_q;
  assign instr_data_o         = data_q;
  assign core_reset_o         = (ld_state != L_DONE);
  assign error_o              = (ld_state == L_ERROR);
  assign busy_o               = busy_q;

endmodule
